status_reg_stack: RTL and testbench

- Parametrised successor to the CPU processor-status flag register.
- Holds WIDTH flag bits with a per-bit load, set and clear mask interface and a bulk load (PLP-style).
- Adds a DEPTH-entry shadow stack that saves and restores the status word on interrupt entry and return (IRQ/NMI/BRK and RTI).
- Adds hardwired-bit masking, and sticky overflow and underflow error flags for the stack.

---
 rtl/status_reg_stack.sv | 166 ++++++++++++++++
 tb/tb_status_reg_stack.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/status_reg_stack.sv
// status_reg_stack
// -----------------------------------------------------------------------------
// Processor-status flag register with per-bit load/set/clear masks, a bulk
// load path, and a DEPTH-entry shadow stack used to save the status word on
// interrupt entry and restore it on return. Hardwired bits (FIXED_MASK) always
// read as FIXED_VAL. Stack misuse is recorded in sticky Overflow/Underflow
// flags.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   Bulk_Load  in   load the whole word from Data_In
//   Data_In    in   [WIDTH]  bulk load value
//   Load_Mask  in   [WIDTH]  per-bit load enable
//   Load_Val   in   [WIDTH]  per-bit load value
//   Set_Mask   in   [WIDTH]  per-bit set
//   Clr_Mask   in   [WIDTH]  per-bit clear (wins over set)
//   Push       in   save current status word onto the shadow stack
//   Pop        in   restore status word from the stack top
//   Err_Clr    in   clear the sticky error flags
//   Data_Out   out  [WIDTH]  current status word
//   Depth      out  [$clog2(DEPTH+1)]  occupied stack entries
//   Full       out  Depth == DEPTH
//   Empty      out  Depth == 0
//   Overflow   out  sticky: a push was dropped
//   Underflow  out  sticky: a pop was ignored
// -----------------------------------------------------------------------------
module status_reg_stack #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = 8'h00,
    parameter logic [WIDTH-1:0] FIXED_MASK = 8'h20,
    parameter logic [WIDTH-1:0] FIXED_VAL  = 8'h20
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Bulk_Load,
    input  logic [WIDTH-1:0]             Data_In,
    input  logic [WIDTH-1:0]             Load_Mask,
    input  logic [WIDTH-1:0]             Load_Val,
    input  logic [WIDTH-1:0]             Set_Mask,
    input  logic [WIDTH-1:0]             Clr_Mask,
    input  logic                         Push,
    input  logic                         Pop,
    input  logic                         Err_Clr,
    output logic [WIDTH-1:0]             Data_Out,
    output logic [$clog2(DEPTH+1)-1:0]   Depth,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int DW = $clog2(DEPTH + 1);

    // Force the hardwired bits of a status word to their constant value.
    function automatic logic [WIDTH-1:0] force_fixed(input logic [WIDTH-1:0] w);
        return (w & ~FIXED_MASK) | (FIXED_VAL & FIXED_MASK);
    endfunction

    localparam logic [WIDTH-1:0] RESET_WORD = force_fixed(RESET_VAL);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [DW-1:0]    depth_r;
    logic             ovf_r;
    logic             unf_r;

    logic             full_s;
    logic             empty_s;
    logic             swap_s;
    logic             push_acc_s;
    logic             pop_acc_s;
    logic             restore_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] next_s;

    assign full_s  = (depth_r == DW'(DEPTH));
    assign empty_s = (depth_r == {DW{1'b0}});

    // Push+Pop on a non-empty stack exchanges the top with the current word.
    // Push+Pop on an empty stack degrades to an accepted push and an ignored
    // pop, which falls out of the terms below because swap_s is then low.
    assign swap_s     = Push & Pop & ~empty_s;
    assign push_acc_s = Push & ~swap_s & ~full_s;
    assign pop_acc_s  = Pop  & ~swap_s & ~empty_s;
    assign restore_s  = swap_s | pop_acc_s;
    assign ovf_evt_s  = Push & ~swap_s & full_s;
    assign unf_evt_s  = Pop & empty_s;

    // Select the stack top, stack_r[depth_r-1]; zero when empty (never used then).
    always_comb begin
        top_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (depth_r == DW'(i + 1)) ? stack_r[i] : top_s;
        end
    end

    // Next status word: base select, then load, set, clear, hardwired bits.
    always_comb begin
        base_s = data_r;
        if (restore_s) begin
            base_s = top_s;
        end else if (Bulk_Load) begin
            base_s = Data_In;
        end else begin
            base_s = data_r;
        end
        next_s = (base_s & ~Load_Mask) | (Load_Val & Load_Mask);
        next_s = next_s | Set_Mask;
        next_s = next_s & ~Clr_Mask;
        next_s = force_fixed(next_s);
    end

    // Status word, stack pointer and sticky error flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data_r  <= RESET_WORD;
            depth_r <= {DW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            data_r <= next_s;
            if (push_acc_s) begin
                depth_r <= depth_r + DW'(1);
            end else if (pop_acc_s) begin
                depth_r <= depth_r - DW'(1);
            end else begin
                depth_r <= depth_r;
            end
            // A new event in the same cycle as Err_Clr keeps the flag set.
            ovf_r <= ovf_evt_s | (ovf_r & ~Err_Clr);
            unf_r <= unf_evt_s | (unf_r & ~Err_Clr);
        end
    end

    // Shadow stack storage: push writes slot depth, swap rewrites slot depth-1,
    // both with the pre-update status word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((push_acc_s && (depth_r == DW'(i))) ||
                    (swap_s && (depth_r == DW'(i + 1)))) begin
                    stack_r[i] <= data_r;
                end else begin
                    stack_r[i] <= stack_r[i];
                end
            end
        end
    end

    assign Data_Out  = data_r;
    assign Depth     = depth_r;
    assign Full      = full_s;
    assign Empty     = empty_s;
    assign Overflow  = ovf_r;
    assign Underflow = unf_r;

endmodule

// File: tb/tb_status_reg_stack.sv
// Scoreboard bench for status_reg_stack (default parameters: WIDTH=8, DEPTH=4,
// bit 5 hardwired to 1). The driver queues the hand-computed post-edge state
// for each directed cycle; a monitor pops and compares after every rising edge.
module tb_status_reg_stack;

    logic       Clk;
    logic       Reset;
    logic       Bulk_Load;
    logic [7:0] Data_In;
    logic [7:0] Load_Mask;
    logic [7:0] Load_Val;
    logic [7:0] Set_Mask;
    logic [7:0] Clr_Mask;
    logic       Push;
    logic       Pop;
    logic       Err_Clr;
    logic [7:0] Data_Out;
    logic [2:0] Depth;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       Underflow;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string      nm;
        logic [7:0] data;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];

    status_reg_stack dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Bulk_Load (Bulk_Load),
        .Data_In   (Data_In),
        .Load_Mask (Load_Mask),
        .Load_Val  (Load_Val),
        .Set_Mask  (Set_Mask),
        .Clr_Mask  (Clr_Mask),
        .Push      (Push),
        .Pop       (Pop),
        .Err_Clr   (Err_Clr),
        .Data_Out  (Data_Out),
        .Depth     (Depth),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] d, input logic [2:0] dp,
                           input logic o, input logic u);
        chk({nm, ".data"},  Data_Out, d);
        chk({nm, ".depth"}, {5'd0, Depth}, {5'd0, dp});
        chk({nm, ".full"},  {7'd0, Full},  {7'd0, (dp == 3'd4)});
        chk({nm, ".empty"}, {7'd0, Empty}, {7'd0, (dp == 3'd0)});
        chk({nm, ".ovf"},   {7'd0, Overflow},  {7'd0, o});
        chk({nm, ".unf"},   {7'd0, Underflow}, {7'd0, u});
    endtask

    // Monitor: compare the state presented after each rising edge.
    always @(posedge Clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_all(e.nm, e.data, e.depth, e.ovf, e.unf);
        end
    end

    task automatic cyc(input string nm, input logic bl, input logic [7:0] din,
                       input logic [7:0] lm, input logic [7:0] lv, input logic [7:0] sm,
                       input logic [7:0] cm, input logic ps, input logic pp, input logic ec,
                       input logic [7:0] ed, input logic [2:0] edp, input logic eo,
                       input logic eu);
        exp_t e;
        @(negedge Clk);
        Bulk_Load = bl; Data_In = din; Load_Mask = lm; Load_Val = lv;
        Set_Mask = sm; Clr_Mask = cm; Push = ps; Pop = pp; Err_Clr = ec;
        e.nm = nm; e.data = ed; e.depth = edp; e.ovf = eo; e.unf = eu;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Bulk_Load = 1'b0; Data_In = 8'h00; Load_Mask = 8'h00; Load_Val = 8'h00;
        Set_Mask = 8'h00; Clr_Mask = 8'h00; Push = 1'b0; Pop = 1'b0; Err_Clr = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Bulk_Load = 1'b0; Data_In = 8'h00; Load_Mask = 8'h00; Load_Val = 8'h00;
        Set_Mask = 8'h00; Clr_Mask = 8'h00; Push = 1'b0; Pop = 1'b0; Err_Clr = 1'b0;
        #12;
        chk_all("reset", 8'h20, 3'd0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        // Mask precedence: bulk 00, load bit7, set bits 2/0, clear bit0 -> A4
        cyc("prec",      1'b1, 8'h00, 8'h81, 8'h80, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 8'hA4, 3'd0, 1'b0, 1'b0);
        cyc("fixed_clr", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'hA4, 3'd0, 1'b0, 1'b0);

        // Interrupt nest
        cyc("nest_ld",   1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h21, 3'd0, 1'b0, 1'b0);
        cyc("nest_p1",   1'b0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h25, 3'd1, 1'b0, 1'b0);
        cyc("nest_p2",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h24, 3'd2, 1'b0, 1'b0);
        cyc("nest_r1",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h25, 3'd1, 1'b0, 1'b0);
        cyc("nest_r2",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd0, 1'b0, 1'b0);

        // Overflow: push 20..23 with bulk updates, then a dropped push at 24
        cyc("ovf_ld",    1'b1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 3'd0, 1'b0, 1'b0);
        cyc("ovf_p1",    1'b1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 3'd1, 1'b0, 1'b0);
        cyc("ovf_p2",    1'b1, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 1'b0, 1'b0);
        cyc("ovf_p3",    1'b1, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h23, 3'd3, 1'b0, 1'b0);
        cyc("ovf_p4",    1'b1, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h24, 3'd4, 1'b0, 1'b0);
        cyc("ovf_p5",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h24, 3'd4, 1'b1, 1'b0);
        cyc("ovf_r1",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h23, 3'd3, 1'b1, 1'b0);
        cyc("ovf_r2",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 3'd2, 1'b1, 1'b0);
        cyc("ovf_r3",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd1, 1'b1, 1'b0);
        cyc("ovf_r4",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 3'd0, 1'b1, 1'b0);
        cyc("ovf_clr",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20, 3'd0, 1'b0, 1'b0);

        // Underflow and Err_Clr priority
        cyc("unf_pop",   1'b1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h7A, 3'd0, 1'b0, 1'b1);
        cyc("unf_clr",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7A, 3'd0, 1'b0, 1'b0);
        cyc("unf_both",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7A, 3'd0, 1'b0, 1'b1);
        cyc("unf_clr2",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7A, 3'd0, 1'b0, 1'b0);

        // Swap: top A1 (bit 5 hardwired), current 24
        cyc("swp_ld",    1'b1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA1, 3'd0, 1'b0, 1'b0);
        cyc("swp_push",  1'b1, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h24, 3'd1, 1'b0, 1'b0);
        cyc("swp_swap",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA1, 3'd1, 1'b0, 1'b0);
        cyc("swp_pop",   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h24, 3'd0, 1'b0, 1'b0);

        // Push+Pop while empty: accepted push, ignored pop
        cyc("pp_empty",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h24, 3'd1, 1'b0, 1'b1);
        cyc("pp_pop",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h24, 3'd0, 1'b0, 1'b1);
        cyc("pp_clr",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h24, 3'd0, 1'b0, 1'b0);

        // Reset mid-operation: depth 2, word E3, Underflow set
        cyc("rst_ld",    1'b1, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hE3, 3'd0, 1'b0, 1'b1);
        cyc("rst_p1",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hE3, 3'd1, 1'b0, 1'b1);
        cyc("rst_p2",    1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hE3, 3'd2, 1'b0, 1'b1);
        #3;
        Reset = 1'b1;
        #1;
        chk_all("async_rst", 8'h20, 3'd0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        cyc("post_rst",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
